// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, selects the next PC from sequential, branch,
// jump or register targets, and maintains a circular return-address stack.
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                IMM_W        = 16,
  parameter int                JMP_BITS     = 26,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           PCWre,
  input  logic [1:0]                     pc_src,
  input  logic [IMM_W-1:0]               branch_imm,
  input  logic [JMP_BITS-1:0]            jump_target,
  input  logic [WIDTH-1:0]               reg_target,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           clr_flags,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus4,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] JMP_KEEP = ~((WIDTH'(1) << (JMP_BITS + 2)) - WIDTH'(1));

  logic [WIDTH-1:0]        r_pc;
  logic [PW-1:0]           r_top;
  logic [CW-1:0]           r_count;
  logic                    r_ovf;
  logic                    r_udf;
  logic [WIDTH-1:0]        r_ras [RAS_DEPTH];

  logic [WIDTH-1:0]        w_pc_plus4;
  logic signed [WIDTH-1:0] w_boff;
  logic [WIDTH-1:0]        w_src_pc;
  logic [WIDTH-1:0]        w_next_pc;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop_req;
  logic                    w_pop;
  logic [PW-1:0]           w_wr_idx;

  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_boff     = {{(WIDTH-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(RAS_DEPTH));
  assign w_push     = PCWre & call;
  assign w_pop_req  = PCWre & ret;
  assign w_pop      = w_pop_req & ~w_empty;
  // Simultaneous call+ret on a live stack replaces the top in place.
  assign w_wr_idx   = w_pop ? r_top : r_top + PW'(1);

  always_comb begin
    w_src_pc = w_pc_plus4;
    case (pc_src)
      2'b01:   w_src_pc = w_pc_plus4 + w_boff;
      2'b10:   w_src_pc = (w_pc_plus4 & JMP_KEEP) | (WIDTH'(jump_target) << 2);
      2'b11:   w_src_pc = reg_target & ~WIDTH'(3);
      default: w_src_pc = w_pc_plus4;
    endcase
  end

  assign w_next_pc = w_pop ? r_ras[r_top] : w_src_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_VECTOR;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (PCWre) r_pc <= w_next_pc;
      if (w_push && !w_pop) begin
        r_top <= r_top + PW'(1);
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_top   <= r_top - PW'(1);
        r_count <= r_count - CW'(1);
      end
      // A new event wins over a clear on the same edge.
      r_ovf <= (w_push & w_full & ~w_pop) | (r_ovf & ~clr_flags);
      r_udf <= (w_pop_req & w_empty) | (r_udf & ~clr_flags);
    end
  end

  // Stack contents are data only and are never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_wr_idx] <= w_pc_plus4;
  end

  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign ras_count     = r_count;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_udf;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: reset, next-PC selection, wrap, RAS call/return,
// overflow/underflow and sticky flag clearing.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWre;
  logic [1:0]  pc_src;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic        call, ret, clr_flags;
  logic [31:0] pc, pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .IMM_W(16), .JMP_BITS(26), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .PCWre(PCWre), .pc_src(pc_src), .branch_imm(branch_imm),
    .jump_target(jump_target), .reg_target(reg_target), .call(call), .ret(ret),
    .clr_flags(clr_flags), .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    PCWre = 1'b0; pc_src = 2'b00; branch_imm = '0; jump_target = '0;
    reg_target = '0; call = 1'b0; ret = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_pc(input logic [31:0] a);
    idle(); PCWre = 1'b1; pc_src = 2'b11; reg_target = a;
    tick(); idle();
  endtask

  task automatic do_call();
    idle(); PCWre = 1'b1; call = 1'b1; tick(); idle();
  endtask

  task automatic do_reset();
    reset = 1'b0; #1; reset = 1'b1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b0; #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (ras_count !== 3'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras: count %0d empty %b full %b expected 0 1 0", ras_count, ras_empty, ras_full); end
    #2 reset = 1'b1;
    idle(); PCWre = 1'b1; ret = 1'b1; tick(); idle();
    do_call();
    set_pc(32'h40);
    checks++; if (pc !== 32'h40 || ras_count !== 3'd1 || ras_underflow !== 1'b1) begin errors++; $display("FAIL pre_reset: pc %h count %0d udf %b expected 40 1 1", pc, ras_count, ras_underflow); end
    #3 reset = 1'b0; #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (ras_count !== 3'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL async_reset_ras: count %0d ovf %b udf %b expected 0 0 0", ras_count, ras_overflow, ras_underflow); end
    #2 reset = 1'b1;
  endtask

  task automatic test_branch_jump();
    set_pc(32'h100);
    PCWre = 1'b1; pc_src = 2'b01; branch_imm = 16'hFFFE; tick(); idle();
    checks++; if (pc !== 32'h0FC) begin errors++; $display("FAIL branch_neg: got %h expected %h", pc, 32'h0FC); end
    set_pc(32'h100);
    PCWre = 1'b1; pc_src = 2'b01; branch_imm = 16'd3; tick(); idle();
    checks++; if (pc !== 32'h110) begin errors++; $display("FAIL branch_pos: got %h expected %h", pc, 32'h110); end
    set_pc(32'h0000_1000);
    PCWre = 1'b1; pc_src = 2'b10; jump_target = 26'h40; tick(); idle();
    checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL jump_low: got %h expected %h", pc, 32'h100); end
    set_pc(32'h1000_0000);
    PCWre = 1'b1; pc_src = 2'b10; jump_target = 26'h40; tick(); idle();
    checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump_region: got %h expected %h", pc, 32'h1000_0100); end
    set_pc(32'h0000_0503);
    checks++; if (pc !== 32'h500) begin errors++; $display("FAIL reg_align: got %h expected %h", pc, 32'h500); end
    PCWre = 1'b0; pc_src = 2'b11; reg_target = 32'h999; call = 1'b1; ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h500 || ras_count !== 3'd0) begin errors++; $display("FAIL stall_%0d: pc %h count %0d expected 500 0", i, pc, ras_count); end
    end
    idle();
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL plus4_wrap: got %h expected %h", pc_plus4, 32'h0); end
    PCWre = 1'b1; tick(); idle();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL seq_wrap: got %h expected %h", pc, 32'h0); end
    PCWre = 1'b1; pc_src = 2'b01; branch_imm = 16'hFFFE; tick(); idle();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL branch_wrap: got %h expected %h", pc, 32'hFFFF_FFFC); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_pc(32'h10 * (i + 1));
      do_call();
      checks++; if (ras_count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin errors++; $display("FAIL call_count_%0d: got %0d", i, ras_count); end
    end
    checks++; if (ras_overflow !== 1'b1 || ras_full !== 1'b1 || pc !== 32'h54) begin errors++; $display("FAIL overflow: ovf %b full %b pc %h expected 1 1 54", ras_overflow, ras_full, pc); end
    for (int i = 0; i < 4; i++) begin
      PCWre = 1'b1; ret = 1'b1; tick(); idle();
      checks++; if (pc !== exp_ret[i] || ras_count !== 3'(3 - i)) begin errors++; $display("FAIL ret_%0d: pc %h count %0d expected %h %0d", i, pc, ras_count, exp_ret[i], 3 - i); end
    end
    checks++; if (ras_underflow !== 1'b0 || ras_empty !== 1'b1) begin errors++; $display("FAIL pre_underflow: udf %b empty %b expected 0 1", ras_underflow, ras_empty); end
    PCWre = 1'b1; ret = 1'b1; pc_src = 2'b00; tick(); idle();
    checks++; if (pc !== 32'h28 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin errors++; $display("FAIL underflow: pc %h udf %b count %0d expected 28 1 0", pc, ras_underflow, ras_count); end
  endtask

  task automatic test_flags();
    clr_flags = 1'b1; tick(); idle();
    checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL clr_flags: ovf %b udf %b expected 0 0", ras_overflow, ras_underflow); end
    for (int i = 0; i < 4; i++) do_call();
    checks++; if (ras_overflow !== 1'b0 || ras_count !== 3'd4) begin errors++; $display("FAIL fill: ovf %b count %0d expected 0 4", ras_overflow, ras_count); end
    PCWre = 1'b1; call = 1'b1; clr_flags = 1'b1; tick(); idle();
    checks++; if (ras_overflow !== 1'b1 || ras_count !== 3'd4) begin errors++; $display("FAIL set_beats_clr: ovf %b count %0d expected 1 4", ras_overflow, ras_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_pc(32'h80);
    do_call();
    checks++; if (pc !== 32'h84 || ras_count !== 3'd1) begin errors++; $display("FAIL setup_call: pc %h count %0d expected 84 1", pc, ras_count); end
    set_pc(32'h200);
    PCWre = 1'b1; call = 1'b1; ret = 1'b1; tick(); idle();
    checks++; if (pc !== 32'h84 || ras_count !== 3'd1) begin errors++; $display("FAIL call_ret: pc %h count %0d expected 84 1", pc, ras_count); end
    PCWre = 1'b1; ret = 1'b1; tick(); idle();
    checks++; if (pc !== 32'h204 || ras_count !== 3'd0) begin errors++; $display("FAIL new_top: pc %h count %0d expected 204 0", pc, ras_count); end
    PCWre = 1'b1; call = 1'b1; ret = 1'b1; tick(); idle();
    checks++; if (pc !== 32'h208 || ras_count !== 3'd1 || ras_underflow !== 1'b1) begin errors++; $display("FAIL call_ret_empty: pc %h count %0d udf %b expected 208 1 1", pc, ras_count, ras_underflow); end
    PCWre = 1'b1; ret = 1'b1; tick(); idle();
    checks++; if (pc !== 32'h208 || ras_count !== 3'd0) begin errors++; $display("FAIL pop_after_empty_push: pc %h count %0d expected 208 0", pc, ras_count); end
  endtask

  initial begin
    test_reset();
    test_branch_jump();
    test_wrap();
    test_ras_overflow();
    test_flags();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
